audio_pwm_out: RTL and testbench
================================

// Module: audio_pwm_out
// PURPOSE
//  Audio back end of the AM SDR. Takes the 8-bit signed envelope-detector output once per PWM
//  period. Removes the carrier DC with a first-order high-pass, applies a power-of-two volume
//  gain and saturates. Drives a single-bit PWM pin for an external RC filter and speaker/amp.
// PARAMETERS
//  PWM_BITS  8  PWM resolution; period = 2**PWM_BITS clocks; legal range 8..12
//  DC_K      8  high-pass pole shift; dc tracks input with time constant 2**DC_K samples
// PORTS
//  clk          in   1   system clock, single clock domain
//  RSTb         in   1   asynchronous, active-low reset
//  env_in       in   8   signed envelope sample (two's complement), sampled at period start
//  gain         in   3   volume shift 0..7 (y <<< gain)
//  mute         in   1   force 50% duty and freeze DC estimator
//  pwm_out      out  1   registered PWM output
//  sample_tick  out  1   one-cycle pulse when env_in is captured
//  clip         out  1   one-cycle pulse when the current sample saturated
// BEHAVIOUR
//  - Reset (async, RSTb=0): cnt=0, x_q=0, dc_acc=0, duty=duty_next=2**(PWM_BITS-1),
//    pwm_out=0, sample_tick=0, clip=0. All outputs take effect immediately, with no clock edge.
//  - cnt: free-running PWM_BITS-bit up-counter. It wraps from all-ones to 0 with no stall.
//  - Per-period pipeline, indexed by cnt:
//    cnt==0: x_q<=env_in; sample_tick=1 (combinational decode of cnt==0 registered, aligned to capture)
//    cnt==1: dc=dc_acc>>>DC_K; y=x_q-dc (9-bit signed); dc_acc<=dc_acc+(x_q-dc); y registered
//    cnt==2: v=(y<<<gain)<<<(PWM_BITS-8), full width, no overflow;
//            sat to [-2**(PWM_BITS-1), 2**(PWM_BITS-1)-1]; clip=1 this cycle iff saturated;
//            duty_next<=sat+2**(PWM_BITS-1) (offset binary)
//    cnt wraps (all-ones -> 0): duty<=duty_next
//  - Latency: a sample captured at cnt=0 of period N sets the duty of period N+1.
//  - pwm_out<=(cnt<duty), registered, so it lags cnt by one clock.
//    duty=0 gives a constant low. duty=2**PWM_BITS-1 gives high for all but one clock.
//  - dc_acc width is 8+DC_K+1 signed. Its arithmetic shift rounds toward -inf. It never wraps:
//    |dc|<=128 by construction.
//  - mute=1 sampled at cnt==2: duty_next<=2**(PWM_BITS-1), clip=0. At cnt==1, dc_acc holds its
//    value. Unmute resumes from the held dc.
//  - gain and mute changes apply only at the pipeline stage that reads them. There is no
//    mid-period duty change.
//  - Reset asserted mid-period aborts the pipeline. After release the first capture happens at
//    cnt==0, i.e. the very first clock.
// CONFIGURATION
//  AUDIO_DC_BLOCK_EN defined: high-pass exactly as above.
//  AUDIO_DC_BLOCK_EN undefined: dc_acc is not instantiated, dc=0, y=sign-extended x_q.
//    Latency and all other timing are unchanged.
// STRUCTURE
//  - Shared package sdr_audio_pkg holds: AUDIO_W=8, GAIN_W=3, PWM_BITS_DEF=8, DC_K_DEF=8, and
//    the midscale constant function mid(PWM_BITS).
//  - One sub-module: dc_block. It contains x_q in, y out, an enable strobe, a hold input and
//    dc_acc. It is instantiated only under AUDIO_DC_BLOCK_EN.
//  - Counter, gain/saturate stage and PWM comparator stay in the top module.
// TESTING
//  1. RSTb low for 5 clks then high -> pwm_out=0, clip=0 during reset; sample_tick at
//     clks 0,256,512... after release.
//  2. DC_BLOCK on, env_in=40 const, gain=0 -> first duty=168. It decays monotonically toward
//     128 and is within 128+-1 after 2048 periods.
//  3. DC_BLOCK off, gain=2: env_in=100 -> duty=255 and clip pulse; env_in=-100 -> duty=0,
//     pwm_out low for the whole period.
//  4. Latency: env_in steps 0->50 at cnt=0 of period N (DC_BLOCK off, gain 0) -> period N
//     duty=128, period N+1 duty=178 (178 high clocks).
//  5. mute=1 with env_in=90 -> pwm_out high exactly 128 of 256 clks. dc_acc is unchanged
//     across 10 muted periods. clip is never asserted.
//  6. Assert RSTb at cnt=100 without a clk edge -> pwm_out, sample_tick, clip=0 immediately;
//     duty=128 after release.

Source files
------------

// File: rtl/sdr_audio_pkg.sv
// sdr_audio_pkg: shared widths, defaults and helpers for the AM SDR audio path.
package sdr_audio_pkg;
  localparam int AUDIO_W      = 8;
  localparam int GAIN_W       = 3;
  localparam int PWM_BITS_DEF = 8;
  localparam int DC_K_DEF     = 8;

  function automatic int mid(input int pwm_bits);
    return 1 << (pwm_bits - 1);
  endfunction
endpackage

// File: rtl/dc_block.sv
// dc_block: first-order DC tracker; y = x - (dc_acc >>> DC_K), dc_acc integrates y on each enable strobe.
module dc_block
  import sdr_audio_pkg::*;
#(
  parameter int DC_K = DC_K_DEF
) (
  input  logic                      clk,
  input  logic                      RSTb,
  input  logic                      en,
  input  logic                      hold,
  input  logic signed [AUDIO_W-1:0] x_q,
  output logic signed [AUDIO_W:0]   y
);
  localparam int AW = AUDIO_W + DC_K + 1;

  logic signed [AW-1:0]    dc_acc_q, dc_acc_d, diff;
  logic signed [AUDIO_W:0] dc;

  // The accumulator settles at 2**DC_K times the input mean, so dc always fits in AUDIO_W+1 bits
  always_comb begin
    dc       = (AUDIO_W + 1)'(dc_acc_q >>> DC_K);
    diff     = AW'(x_q) - AW'(dc);
    y        = diff[AUDIO_W:0];
    dc_acc_d = (en && !hold) ? dc_acc_q + diff : dc_acc_q;
  end

  always_ff @(posedge clk or negedge RSTb)
    if (!RSTb) dc_acc_q <= '0;
    else       dc_acc_q <= dc_acc_d;
endmodule

// File: rtl/audio_pwm_out.sv
// audio_pwm_out: AM SDR audio back end -- optional DC block, power-of-two gain, saturating PWM DAC.
// Define AUDIO_DC_BLOCK_EN to place the dc_block high-pass ahead of the gain stage.
module audio_pwm_out
  import sdr_audio_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int DC_K     = DC_K_DEF
) (
  input  logic                      clk,
  input  logic                      RSTb,
  input  logic signed [AUDIO_W-1:0] env_in,
  input  logic        [GAIN_W-1:0]  gain,
  input  logic                      mute,
  output logic                      pwm_out,
  output logic                      sample_tick,
  output logic                      clip
);
  localparam int VW = PWM_BITS + 2 ** GAIN_W;
  localparam logic [PWM_BITS-1:0] MID = PWM_BITS'(mid(PWM_BITS));
  localparam logic [PWM_BITS-1:0] C1  = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] C2  = PWM_BITS'(2);

  if (PWM_BITS < 8 || PWM_BITS > 12 || DC_K < 1) begin : g_param_check
    $error("audio_pwm_out: PWM_BITS must be 8..12 and DC_K >= 1");
  end

  logic [PWM_BITS-1:0]       cnt_q, cnt_d, duty_q, duty_d, duty_next_q, duty_next_d;
  logic signed [AUDIO_W-1:0] x_q, x_d;
  logic signed [AUDIO_W:0]   y_q, y_d, y_hp;
  logic signed [VW-1:0]      v;
  logic                      ovf, pwm_q, pwm_d, tick_q, tick_d, clip_q, clip_d;

`ifdef AUDIO_DC_BLOCK_EN
  dc_block #(.DC_K(DC_K)) u_dc_block (
    .clk  (clk),
    .RSTb (RSTb),
    .en   (cnt_q == C1),
    .hold (mute),
    .x_q  (x_q),
    .y    (y_hp)
  );
`else
  assign y_hp = {x_q[AUDIO_W-1], x_q};
`endif

  // Saturation is detected as the bits above the PWM sign bit disagreeing with it
  always_comb begin
    v           = VW'(y_q) <<< (gain + (PWM_BITS - AUDIO_W));
    ovf         = (v[VW-1:PWM_BITS-1] != '0) && (v[VW-1:PWM_BITS-1] != '1);
    cnt_d       = cnt_q + 1'b1;
    x_d         = (cnt_q == '0) ? env_in : x_q;
    y_d         = (cnt_q == C1) ? y_hp : y_q;
    duty_next_d = (cnt_q != C2) ? duty_next_q :
                  mute          ? MID :
                  !ovf          ? {~v[PWM_BITS-1], v[PWM_BITS-2:0]} :
                  v[VW-1]       ? {PWM_BITS{1'b0}} : {PWM_BITS{1'b1}};
    duty_d      = (cnt_q == '1) ? duty_next_q : duty_q;
    pwm_d       = cnt_q < duty_q;
    tick_d      = cnt_q == '0;
    clip_d      = (cnt_q == C2) && !mute && ovf;
  end

  always_ff @(posedge clk or negedge RSTb)
    if (!RSTb) begin
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      duty_q      <= MID;
      duty_next_q <= MID;
      pwm_q       <= 1'b0;
      tick_q      <= 1'b0;
      clip_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      duty_q      <= duty_d;
      duty_next_q <= duty_next_d;
      pwm_q       <= pwm_d;
      tick_q      <= tick_d;
      clip_q      <= clip_d;
    end

  assign pwm_out     = pwm_q;
  assign sample_tick = tick_q;
  assign clip        = clip_q;
endmodule

// File: tb/tb_audio_pwm_out.sv
// tb_audio_pwm_out: table vectors, hand sequences and randomized periods against a per-sample model.
module tb_audio_pwm_out;
  localparam int N = 256;

  typedef struct {
    int x;
    int g;
    bit m;
    int duty;
    bit clip;
  } vec_t;

  logic              clk = 1'b0, RSTb = 1'b1, mute = 1'b0;
  logic signed [7:0] env_in = '0;
  logic        [2:0] gain = '0;
  logic              pwm_out, sample_tick, clip;

  int   checks = 0, errors = 0, acc = 0, cur = 128;
  vec_t tbl[$];

  audio_pwm_out dut (
    .clk         (clk),
    .RSTb        (RSTb),
    .env_in      (env_in),
    .gain        (gain),
    .mute        (mute),
    .pwm_out     (pwm_out),
    .sample_tick (sample_tick),
    .clip        (clip)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int x, input int g, input bit m, input int d, input bit c);
    vec_t r;
    r.x = x; r.g = g; r.m = m; r.duty = d; r.clip = c;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: one envelope sample -> next period's duty and this period's clip, from plain arithmetic
  task automatic model_step(input int x, input int g, input bit m, output int duty, output bit clp);
    int dc = 0, y, v;
`ifdef AUDIO_DC_BLOCK_EN
    dc = int'($floor(acc / 256.0));
`endif
    y = x - dc;
    if (!m) acc += y;
    y = y & 511;
    if (y > 255) y -= 512;
    v    = y * (1 << g);
    clp  = !m && (v > 127 || v < -128);
    duty = m ? 128 : ((v > 127) ? 127 : (v < -128) ? -128 : v) + 128;
  endtask

  task automatic do_reset();
    int bad = 0;
    #1 RSTb = 1'b0;
    mute = 1'b0; env_in = '0; gain = '0;
    repeat (5) begin
      @(posedge clk); #1;
      bad += int'(pwm_out) + int'(sample_tick) + int'(clip);
    end
    check("reset_outputs_low", bad, 0);
    #2 RSTb = 1'b1;
    acc = 0; cur = 128;
  endtask

  task automatic run_period(input int x, input int g, input bit m, input int exp_hi,
                            input bit exp_clip, input string tag, output int hi);
    bit tick_ok = 1'b1, clip_ok = 1'b1;
    hi = 0;
    env_in = 8'(x); gain = 3'(g); mute = m;
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      hi += int'(pwm_out);
      if (sample_tick != (i == 0)) tick_ok = 1'b0;
      if (clip != (exp_clip && i == 2)) clip_ok = 1'b0;
    end
    check({tag, "_duty"}, hi, exp_hi);
    check({tag, "_tick"}, int'(tick_ok), 1);
    check({tag, "_clip"}, int'(clip_ok), 1);
  endtask

  task automatic step(input int x, input int g, input bit m, input string tag, output int hi);
    int nd;
    bit nc;
    model_step(x, g, m, nd, nc);
    run_period(x, g, m, cur, nc, tag, hi);
    cur = nd;
  endtask

  initial begin
    int hi, prev;
    tbl.push_back(mk(   0, 0, 0, 128, 0));
    tbl.push_back(mk(  50, 0, 0, 178, 0));
    tbl.push_back(mk(  40, 0, 0, 168, 0));
    tbl.push_back(mk( 100, 2, 0, 255, 1));
    tbl.push_back(mk(-100, 2, 0,   0, 1));
    tbl.push_back(mk( 127, 0, 0, 255, 0));
    tbl.push_back(mk(-128, 0, 0,   0, 0));
    tbl.push_back(mk(  64, 1, 0, 255, 1));
    tbl.push_back(mk(  63, 1, 0, 254, 0));
    tbl.push_back(mk( -64, 1, 0,   0, 0));
    tbl.push_back(mk( -65, 1, 0,   0, 1));
    tbl.push_back(mk(  90, 0, 1, 128, 0));
    tbl.push_back(mk(   1, 7, 0, 255, 1));
    tbl.push_back(mk(  -1, 7, 0,   0, 0));

    do_reset();
    step(0, 0, 0, "first", hi);
    step(0, 0, 0, "second", hi);

    foreach (tbl[i]) begin
      do_reset();
      run_period(tbl[i].x, tbl[i].g, tbl[i].m, 128, tbl[i].clip, $sformatf("tbl%0d_cap", i), hi);
      run_period(0, 0, 0, tbl[i].duty, 1'b0, $sformatf("tbl%0d_next", i), hi);
    end

    do_reset();
    step(0, 0, 0, "pre_abort", hi);
    repeat (100) @(posedge clk);
    #3 check("abort_pwm_before", int'(pwm_out), 1);
    RSTb = 1'b0;
    #1 check("abort_pwm", int'(pwm_out), 0);
    check("abort_tick", int'(sample_tick), 0);
    check("abort_clip", int'(clip), 0);
    @(posedge clk);
    #3 RSTb = 1'b1;
    acc = 0; cur = 128;
    step(50, 0, 0, "post_abort0", hi);
    step(0, 0, 0, "post_abort1", hi);

    do_reset();
    repeat (3) step(90, 0, 0, "pre_mute", hi);
    for (int k = 0; k < 10; k++) step(90, 3, 1, $sformatf("mute%0d", k), hi);
    repeat (3) step(90, 0, 0, "unmute", hi);
    step(-20, 3, 0, "unmute_neg", hi);

    do_reset();
    for (int k = 0; k < 80; k++)
      step(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 3)),
           $urandom_range(0, 4) == 0, $sformatf("rnd%0d", k), hi);

`ifdef AUDIO_DC_BLOCK_EN
    do_reset();
    prev = 256;
    for (int k = 0; k < 30; k++) begin
      step(40, 0, 0, $sformatf("decay%0d", k), hi);
      check($sformatf("decay%0d_mono", k), int'(hi <= prev), 1);
      prev = hi;
    end
`else
    prev = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
